fetch: RTL

- Y86-64 pipeline fetch stage. Holds the F pipeline register (predicted PC) and selects the actual PC from misprediction and return feedback.
- Reads the instruction from a byte-addressed instruction memory, splits and aligns its fields, and computes valP and the next predicted PC.
- Drives the f_* signals that the D pipeline register captures each clock edge.
- Includes a write port so the bench or a loader can fill instruction memory.

---
 rtl/fetch_if.sv | 44 ++++
 rtl/fetch.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus: feedback from later pipeline stages, the instruction
// memory load port, and the F register / f_* values handed to decode.
interface fetch_if;
    // Feedback and stall control from the rest of the pipeline
    logic        F_stall;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;

    // Instruction memory loader port
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [7:0]  imem_wdata;

    // Fetch results
    logic [63:0] F_predPC;
    logic [63:0] f_pc;
    logic [2:0]  f_stat;
    logic [3:0]  f_icode;
    logic [3:0]  f_ifun;
    logic [3:0]  f_rA;
    logic [3:0]  f_rB;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic [63:0] f_predPC;

    // Pipeline / loader side
    modport master (
        output F_stall, M_icode, M_Cnd, M_valA, W_icode, W_valM,
        output imem_we, imem_addr, imem_wdata,
        input  F_predPC, f_pc, f_stat, f_icode, f_ifun, f_rA, f_rB,
        input  f_valC, f_valP, f_predPC
    );

    // Fetch stage side
    modport slave (
        input  F_stall, M_icode, M_Cnd, M_valA, W_icode, W_valM,
        input  imem_we, imem_addr, imem_wdata,
        output F_predPC, f_pc, f_stat, f_icode, f_ifun, f_rA, f_rB,
        output f_valC, f_valP, f_predPC
    );
endinterface

// File: rtl/fetch.sv
// Y86-64 fetch stage: F register holding the predicted PC, PC selection from
// mispredict / ret feedback, byte-addressed instruction memory, instruction
// field alignment, valP and next-PC prediction.
module fetch #(
    parameter int          IMEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC   = 64'h0
) (
    input logic   clk,
    input logic   rst_n,
    fetch_if.slave bus
);
    localparam int          AW         = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_BYTES);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] I_HALT = 4'h0;
    localparam logic [3:0] I_NOP  = 4'h1;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;
    localparam logic [3:0] R_NONE = 4'hF;

    logic [7:0]  mem [IMEM_BYTES];
    logic [63:0] pred_pc_q;

    logic [63:0] pc;
    logic [63:0] byte_addr [10];
    logic [7:0]  fbyte     [10];
    logic [9:0]  in_range;

    logic [3:0]  raw_icode;
    logic [3:0]  raw_ifun;
    logic        need_regids;
    logic        need_valc;
    logic        icode_ok;
    logic [3:0]  ins_len;
    logic [9:0]  req_mask;
    logic        imem_error;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [2:0]  stat;

    // F register: reset beats stall; otherwise follow the prediction unless stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pred_pc_q <= RESET_PC;
        end else if (!bus.F_stall) begin
            pred_pc_q <= bus.f_predPC;
        end
    end

    // Instruction memory write port; out-of-range addresses are dropped, not aliased
    always_ff @(posedge clk) begin
        if (bus.imem_we && (bus.imem_addr < IMEM_LIMIT)) begin
            mem[bus.imem_addr[AW-1:0]] <= bus.imem_wdata;
        end
    end

    // PC select: a jXX mispredict outranks a ret, which outranks the prediction
    always_comb begin
        pc = pred_pc_q;
        if (bus.M_icode == I_JXX && !bus.M_Cnd) begin
            pc = bus.M_valA;
        end else if (bus.W_icode == I_RET) begin
            pc = bus.W_valM;
        end
    end

    // Read the ten bytes an instruction can span; missing bytes read as zero
    always_comb begin
        for (int i = 0; i < 10; i++) begin
            byte_addr[i] = pc + 64'(i);
            in_range[i]  = byte_addr[i] < IMEM_LIMIT;
            fbyte[i]     = in_range[i] ? mem[byte_addr[i][AW-1:0]] : 8'h00;
        end
    end

    // Decode byte 0, size the instruction and check every byte it occupies
    always_comb begin
        raw_icode = fbyte[0][7:4];
        raw_ifun  = fbyte[0][3:0];

        need_regids = 1'b0;
        need_valc   = 1'b0;
        case (raw_icode)
            4'h2, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
            4'h3, 4'h4, 4'h5: begin
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            4'h7, 4'h8:             need_valc   = 1'b1;
            default: ;
        endcase
        icode_ok = raw_icode <= 4'hB;

        ins_len = 4'd1 + {3'd0, need_regids} + {need_valc, 3'd0};
        for (int i = 0; i < 10; i++) begin
            req_mask[i] = 4'(i) < ins_len;
        end
        imem_error = |(req_mask & ~in_range);

        valc = 64'h0;
        if (need_valc) begin
            for (int k = 0; k < 8; k++) begin
                valc[8*k +: 8] = need_regids ? fbyte[k+2] : fbyte[k+1];
            end
        end
        valp = pc + 64'(ins_len);
    end

    // Status and opcode override: ADR before INS, faulting fetches become nops
    always_comb begin
        icode = raw_icode;
        ifun  = raw_ifun;
        stat  = STAT_AOK;
        if (imem_error) begin
            icode = I_NOP;
            ifun  = 4'h0;
            stat  = STAT_ADR;
        end else if (!icode_ok) begin
            icode = I_NOP;
            ifun  = 4'h0;
            stat  = STAT_INS;
        end else if (raw_icode == I_HALT) begin
            stat  = STAT_HLT;
        end
    end

    // Drive decode-facing outputs; jumps and calls predict their target
    always_comb begin
        bus.F_predPC = pred_pc_q;
        bus.f_pc     = pc;
        bus.f_stat   = stat;
        bus.f_icode  = icode;
        bus.f_ifun   = ifun;
        bus.f_rA     = need_regids ? fbyte[1][7:4] : R_NONE;
        bus.f_rB     = need_regids ? fbyte[1][3:0] : R_NONE;
        bus.f_valC   = valc;
        bus.f_valP   = valp;
        bus.f_predPC = (icode == I_JXX || icode == I_CALL) ? valc : valp;
    end
endmodule
